mem_arbiter: RTL and testbench

//  Shares the single-port system memory (ROM+RAM) between the 6502 core and a DMA/loader port.
//  The DMA port is used by benches, the ROM loader and the future debug monitor.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_fsm.sv | 55 +++++
 rtl/mem_arbiter.sv | 66 ++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory arbiter
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   // Ownership of the memory port in the cycle just completed
   typedef enum logic [1:0] {
      CPU_OWN = 2'd0,
      DMA_OWN = 2'd1,
      YIELD   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arb_fsm.sv
// rtl/mem_arb_fsm.sv - grant decision, burst limiter and saturating stall counter
module mem_arb_fsm
   import mem_arb_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int STALL_W   = 16
)
(
   input  logic               ph1,
   input  logic               reset,
   input  logic               dma_req,
   input  logic               cpu_we,
   output logic               dma_gnt,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam int CTR_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
   // Grant index that closes a burst (burst_ctr + 1 == MAX_BURST)
   localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(MAX_BURST - 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [CTR_W-1:0] burst_ctr;
   logic [CTR_W-1:0] ctr_nxt;

   // Grant only on CPU read cycles, never in the forced CPU slot, never in reset
   always_comb begin
      dma_gnt   = dma_req & ~cpu_we & (state != YIELD) & ~reset;
      state_nxt = CPU_OWN;
      ctr_nxt   = '0;
      if (dma_gnt && (burst_ctr == LAST_IDX)) begin
         state_nxt = YIELD;
         ctr_nxt   = '0;
      end else if (dma_gnt) begin
         state_nxt = DMA_OWN;
         ctr_nxt   = burst_ctr + CTR_W'(1);
      end
   end

   // State, burst length and stall count registers
   always_ff @(posedge ph1) begin
      if (reset) begin
         state     <= CPU_OWN;
         burst_ctr <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         burst_ctr <= ctr_nxt;
         if (dma_gnt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single-port system memory between the 6502 core and DMA
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = 4,
   parameter int STALL_W   = 16
)
(
   input  logic               ph1,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic               cpu_we,
   input  logic [DATA_W-1:0]  cpu_wdata,
   output logic               cpu_rdy,
   output logic [DATA_W-1:0]  cpu_rdata,
   input  logic               dma_req,
   input  logic [ADDR_W-1:0]  dma_addr,
   input  logic               dma_we,
   input  logic [DATA_W-1:0]  dma_wdata,
   output logic               dma_gnt,
   output logic               dma_rvalid,
   output logic [DATA_W-1:0]  dma_rdata,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic [STALL_W-1:0] stall_cnt
);

   logic last_dma_rd;

   mem_arb_fsm #(
      .MAX_BURST (MAX_BURST),
      .STALL_W   (STALL_W)
   ) u_fsm (
      .ph1       (ph1),
      .reset     (reset),
      .dma_req   (dma_req),
      .cpu_we    (cpu_we),
      .dma_gnt   (dma_gnt),
      .stall_cnt (stall_cnt)
   );

   // Exactly one owner drives memory; no write can leak out while in reset
   always_comb begin
      cpu_rdy    = ~dma_gnt;
      mem_addr   = dma_gnt ? dma_addr  : cpu_addr;
      mem_wdata  = dma_gnt ? dma_wdata : cpu_wdata;
      mem_we     = ~reset & (dma_gnt ? dma_we : cpu_we);
      cpu_rdata  = mem_rdata;
      dma_rdata  = mem_rdata;
      dma_rvalid = last_dma_rd;
   end

   // Remember a granted DMA read so its data is flagged when memory returns it
   always_ff @(posedge ph1) begin
      if (reset) begin
         last_dma_rd <= 1'b0;
      end else begin
         last_dma_rd <= dma_gnt & ~dma_we;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

   logic        ph1 = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic        dma_we;
   logic [7:0]  dma_wdata;
   logic [7:0]  mem_rdata = 8'h00;

   logic        cpu_rdy, dma_gnt, dma_rvalid, mem_we;
   logic [7:0]  cpu_rdata, dma_rdata, mem_wdata;
   logic [15:0] mem_addr, stall_cnt;

   logic        b1_cpu_rdy, b1_dma_gnt, b1_dma_rvalid, b1_mem_we;
   logic [7:0]  b1_cpu_rdata, b1_dma_rdata, b1_mem_wdata;
   logic [15:0] b1_mem_addr, b1_stall_cnt;

   logic        s2_cpu_rdy, s2_dma_gnt, s2_dma_rvalid, s2_mem_we;
   logic [7:0]  s2_cpu_rdata, s2_dma_rdata, s2_mem_wdata;
   logic [15:0] s2_mem_addr;
   logic [1:0]  s2_stall_cnt;

   logic [7:0]  mem [0:65535];
   logic [7:0]  cpu_q[$];
   logic [7:0]  dma_q[$];
   logic        cpu_chk   = 1'b0;
   logic        cpu_chk_d = 1'b0;
   int          errors = 0;
   int          checks = 0;

   logic [9:0]  pat4 = 10'b1111011110;
   logic [9:0]  pat1 = 10'b1010101010;
   logic [4:0]  pat6 = 5'b11110;

   always #5 ph1 = ~ph1;

   mem_arbiter dut (
      .ph1(ph1), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
   );

   mem_arbiter #(.MAX_BURST(1)) dut_b1 (
      .ph1(ph1), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_rdy(b1_cpu_rdy), .cpu_rdata(b1_cpu_rdata),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
      .dma_gnt(b1_dma_gnt), .dma_rvalid(b1_dma_rvalid), .dma_rdata(b1_dma_rdata),
      .mem_addr(b1_mem_addr), .mem_we(b1_mem_we), .mem_wdata(b1_mem_wdata),
      .mem_rdata(mem_rdata), .stall_cnt(b1_stall_cnt)
   );

   mem_arbiter #(.MAX_BURST(4), .STALL_W(2)) dut_s2 (
      .ph1(ph1), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_rdy(s2_cpu_rdy), .cpu_rdata(s2_cpu_rdata),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
      .dma_gnt(s2_dma_gnt), .dma_rvalid(s2_dma_rvalid), .dma_rdata(s2_dma_rdata),
      .mem_addr(s2_mem_addr), .mem_we(s2_mem_we), .mem_wdata(s2_mem_wdata),
      .mem_rdata(mem_rdata), .stall_cnt(s2_stall_cnt)
   );

   // Synchronous memory, 1-cycle read latency, ROM above $E000
   always @(posedge ph1) begin
      if (mem_we && (mem_addr < 16'hE000)) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic req, input logic dwe, input logic [15:0] da,
                        input logic [7:0] dwd, input logic cwe, input logic [15:0] ca,
                        input logic [7:0] cwd, input logic chk);
      dma_req   = req;
      dma_we    = dwe;
      dma_addr  = da;
      dma_wdata = dwd;
      cpu_we    = cwe;
      cpu_addr  = ca;
      cpu_wdata = cwd;
      cpu_chk   = chk;
   endtask

   task automatic tick();
      @(posedge ph1);
      #1;
   endtask

   // Monitor: pops expected read data whenever a read result is presented
   always @(posedge ph1) cpu_chk_d <= cpu_chk;

   always @(negedge ph1) begin
      logic [7:0] e;
      if (cpu_chk_d) begin
         if (cpu_q.size() == 0) check("cpu_q_underflow", 1, 0);
         else begin
            e = cpu_q.pop_front();
            check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e});
         end
      end
      if (dma_rvalid === 1'b1) begin
         if (dma_q.size() == 0) check("dma_rvalid_unexpected", 1, 0);
         else begin
            e = dma_q.pop_front();
            check("dma_rdata", {24'd0, dma_rdata}, {24'd0, e});
         end
      end
   end

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h0030] = 8'h3C;
      mem[16'hFFFB] = 8'hEA;
      mem[16'hFFFC] = 8'h00;
      mem[16'hFFFD] = 8'hEA;

      // Reset: no grant, core ready, no memory write
      reset = 1'b1;
      drive(1, 0, 16'h0200, 8'h00, 0, 16'h0030, 8'h00, 0);
      @(negedge ph1);
      check("rst_gnt", {31'd0, dma_gnt}, 0);
      check("rst_rdy", {31'd0, cpu_rdy}, 1);
      tick();
      drive(0, 0, 16'h0000, 8'h00, 1, 16'h0030, 8'hAA, 0);
      @(negedge ph1);
      check("rst_mem_we", {31'd0, mem_we}, 0);
      tick();
      reset = 1'b0;

      // 1: plain core reads
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 16'h0000, 8'h00, 0, 16'h0030, 8'h00, 1);
         cpu_q.push_back(8'h3C);
         @(negedge ph1);
         check("t1_rdy", {31'd0, cpu_rdy}, 1);
         check("t1_addr", {16'd0, mem_addr}, 32'h0030);
         check("t1_stall", {16'd0, stall_cnt}, 0);
         tick();
      end

      // 2: DMA write steals a core read cycle, then read back
      drive(1, 1, 16'h0200, 8'h9D, 0, 16'h0030, 8'h00, 0);
      @(negedge ph1);
      check("t2_gnt", {31'd0, dma_gnt}, 1);
      check("t2_rdy", {31'd0, cpu_rdy}, 0);
      check("t2_mem_we", {31'd0, mem_we}, 1);
      check("t2_mem_addr", {16'd0, mem_addr}, 32'h0200);
      check("t2_mem_wdata", {24'd0, mem_wdata}, 32'h9D);
      tick();
      drive(1, 0, 16'h0200, 8'h00, 0, 16'h0030, 8'h00, 0);
      dma_q.push_back(8'h9D);
      @(negedge ph1);
      check("t2_wr_no_rvalid", {31'd0, dma_rvalid}, 0);
      check("t2_rd_gnt", {31'd0, dma_gnt}, 1);
      tick();
      drive(0, 0, 16'h0000, 8'h00, 0, 16'h0200, 8'h00, 1);
      cpu_q.push_back(8'h9D);
      @(negedge ph1);
      check("t2_rvalid", {31'd0, dma_rvalid}, 1);
      tick();

      // 3: DMA request during a core write waits one cycle
      drive(1, 0, 16'h0030, 8'h00, 1, 16'h0030, 8'h55, 0);
      @(negedge ph1);
      check("t3_gnt", {31'd0, dma_gnt}, 0);
      check("t3_rdy", {31'd0, cpu_rdy}, 1);
      check("t3_mem_we", {31'd0, mem_we}, 1);
      check("t3_mem_addr", {16'd0, mem_addr}, 32'h0030);
      check("t3_mem_wdata", {24'd0, mem_wdata}, 32'h55);
      tick();
      drive(1, 0, 16'h0030, 8'h00, 0, 16'h0040, 8'h00, 0);
      dma_q.push_back(8'h55);
      @(negedge ph1);
      check("t3_gnt_next", {31'd0, dma_gnt}, 1);
      check("t3_addr_next", {16'd0, mem_addr}, 32'h0030);
      check("t3_we_next", {31'd0, mem_we}, 0);
      tick();
      drive(0, 0, 16'h0000, 8'h00, 0, 16'h0030, 8'h00, 1);
      cpu_q.push_back(8'h55);
      @(negedge ph1);
      check("t3_stall", {16'd0, stall_cnt}, 3);
      tick();

      // 4: continuous request, burst limit and saturation
      reset = 1'b1;
      drive(0, 0, 16'h0000, 8'h00, 0, 16'h0030, 8'h00, 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 16'h0300, 8'h77, 0, 16'h0030, 8'h00, 0);
         @(negedge ph1);
         check("t4_gnt", {31'd0, dma_gnt}, {31'd0, pat4[9-i]});
         check("t4_rdy", {31'd0, cpu_rdy}, {31'd0, ~pat4[9-i]});
         check("t4_gnt_mb1", {31'd0, b1_dma_gnt}, {31'd0, pat1[9-i]});
         tick();
      end
      drive(0, 0, 16'h0000, 8'h00, 0, 16'h0030, 8'h00, 0);
      @(negedge ph1);
      check("t4_stall", {16'd0, stall_cnt}, 8);
      check("t4_stall_mb1", {16'd0, b1_stall_cnt}, 5);
      check("t4_stall_sat", {30'd0, s2_stall_cnt}, 3);
      tick();

      // 5: DMA read from ROM
      drive(1, 0, 16'hFFFC, 8'h00, 0, 16'h0030, 8'h00, 0);
      dma_q.push_back(8'h00);
      @(negedge ph1);
      check("t5_gnt", {31'd0, dma_gnt}, 1);
      check("t5_rvalid_same", {31'd0, dma_rvalid}, 0);
      tick();
      drive(0, 0, 16'h0000, 8'h00, 0, 16'h0030, 8'h00, 0);
      @(negedge ph1);
      check("t5_rvalid", {31'd0, dma_rvalid}, 1);
      tick();
      @(negedge ph1);
      check("t5_rvalid_once", {31'd0, dma_rvalid}, 0);
      tick();

      // 6: reset on the 2nd cycle of a burst
      drive(1, 0, 16'h0200, 8'h00, 0, 16'h0030, 8'h00, 0);
      dma_q.push_back(8'h9D);
      @(negedge ph1);
      check("t6_gnt1", {31'd0, dma_gnt}, 1);
      tick();
      reset = 1'b1;
      @(negedge ph1);
      check("t6_rst_gnt", {31'd0, dma_gnt}, 0);
      check("t6_rst_rdy", {31'd0, cpu_rdy}, 1);
      tick();
      reset = 1'b0;
      drive(0, 0, 16'h0000, 8'h00, 0, 16'h0030, 8'h00, 0);
      @(negedge ph1);
      check("t6_post_gnt", {31'd0, dma_gnt}, 0);
      check("t6_post_rvalid", {31'd0, dma_rvalid}, 0);
      check("t6_post_rdy", {31'd0, cpu_rdy}, 1);
      check("t6_post_stall", {16'd0, stall_cnt}, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 16'h0300, 8'h11, 0, 16'h0030, 8'h00, 0);
         @(negedge ph1);
         check("t6_burst_gnt", {31'd0, dma_gnt}, {31'd0, pat6[4-i]});
         tick();
      end
      drive(0, 0, 16'h0000, 8'h00, 0, 16'h0030, 8'h00, 0);
      @(negedge ph1);
      check("t6_stall", {16'd0, stall_cnt}, 4);
      tick();
      @(negedge ph1);
      #1;
      check("cpu_q_drained", cpu_q.size(), 0);
      check("dma_q_drained", dma_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
